l1_mem_responder: RTL and testbench
===================================

# l1_mem_responder

Backing-memory responder for the L1 data cache's downstream (miss/eviction) port. It accepts one line-sized request at a time from the cache's refill/writeback controller. Read requests are served as a burst of 32-bit beats after a programmable latency. Write requests absorb a burst of beats into an internal word array. The block sits below `l1d`, takes its line geometry from `cache_pkg`, and doubles as the memory model for L1D benches.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width (matches `cache_pkg`).
- `LINE_BYTES`, 64, line size in bytes (matches `L1_LINE_SIZE`); power of two, ≥ 4.
- `MEM_WORDS`, 1024, depth of the 32-bit word array; power of two.
- `RD_LATENCY`, 4, idle cycles between read acceptance and first beat; 0–15.
- Derived: `BEATS = LINE_BYTES/4`.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  0 = line read (refill), 1 = line write (writeback).
- `req_addr`  in  ADDR_WIDTH  byte address; low log2(LINE_BYTES) bits ignored.
- `wdata_valid`  in  1  write beat present.
- `wdata`  in  32  write beat data.
- `wdata_ready`  out  1  high only in WBURST.
- `wr_done`  out  1  one-cycle pulse after the last write beat.
- `rdata_valid`  out  1  read beat present.
- `rdata`  out  32  read beat data.
- `rdata_last`  out  1  high with the final beat (index BEATS-1).
- `rdata_ready`  in  1  consumer accepts the beat.

## Operation
- FSM states: IDLE, WAIT, RBURST, WBURST, WRESP.
- IDLE: `req_ready=1`. The request is accepted when `req_valid && req_ready`. On acceptance, latch base word index = (`req_addr` >> 2) with the beat bits cleared, modulo MEM_WORDS, and clear the beat counter.
  - Read with RD_LATENCY>0 → WAIT, and the latency counter loads RD_LATENCY.
  - Read with RD_LATENCY=0 → RBURST.
  - Write → WBURST.
- WAIT: the counter decrements each cycle. On the cycle it reaches 1 → RBURST.
- RBURST: `rdata_valid=1`, and `rdata` = mem[base+beat].
  - On `rdata_valid && rdata_ready`, the beat increments.
  - `rdata`, `rdata_valid` and `rdata_last` hold stable while `rdata_ready=0`.
  - After the handshake on beat BEATS-1 → IDLE.
- WBURST: `wdata_ready=1`.
  - On `wdata_valid && wdata_ready`, mem[base+beat] ← `wdata` and the beat increments.
  - After the handshake on beat BEATS-1 → WRESP.
- WRESP: `wr_done=1` for exactly one cycle → IDLE.
- Address arithmetic: base+beat never carries out of the line, because the base is line-aligned. The line index wraps modulo MEM_WORDS/BEATS, so addresses beyond the array alias.
- Only one outstanding request at a time. No new request is accepted until the FSM is back in IDLE.
- The memory array is not cleared by reset and has no read/write port exposed outside the protocol.
- `rdata` is driven from a register. The implementation prefetches the next word so that back-to-back beats need no bubble.

## Timing
- Reset, when `rst=1` at an edge:
  - State → IDLE; counters are cleared.
  - `req_ready=1` and all other outputs = 0, including `rdata=0`.
  - Memory contents are preserved.
  - Reset mid-burst drops the burst. Words already written stay written.
- Read latency: with the request accepted at edge T, the first `rdata_valid` appears in the cycle after edge T+RD_LATENCY (RD_LATENCY=0 → cycle after T).
- With `rdata_ready` held high, one beat per cycle: BEATS consecutive cycles, with `rdata_last` on the final one.
- `req_ready` returns high in the cycle after the last read handshake, or the cycle after WRESP.
- Write: `wdata_ready` is high from the cycle after acceptance. `wr_done` pulses in the cycle after the last beat handshake.
- `req_valid` while busy is ignored, not queued. The requester must hold it until `req_ready`.
- `wdata_valid` outside WBURST is ignored.

## Test plan
- Reset: `rst=1` for 2 cycles → `req_ready=1`, `rdata_valid=0`, `wdata_ready=0`, `wr_done=0`, `rdata=0`.
- Write then read, with RD_LATENCY=4:
  - Write addr 0x0000_0040 with beats 0xA000_0000+i (i=0..15) → `wr_done` pulses once, 1 cycle after beat 15.
  - Read addr 0x0000_0044 → first beat 5 cycles after acceptance; 16 beats 0xA000_0000..0xA000_000F in order, `rdata_last` only on the 16th.
- Backpressure: during a read, drop `rdata_ready` for 3 cycles at beat 7 → beat 7 data held stable; no beat skipped or duplicated; total 16 handshakes.
- Write gaps: deassert `wdata_valid` every other cycle → exactly 16 words stored (checked by readback); `wr_done` only after the 16th handshake.
- Alias: write line at addr 0 with pattern P, read addr MEM_WORDS*4 → P returned. A `req_valid` pulse during the burst is not accepted.
- Reset mid-read at beat 3 → next cycle IDLE, `rdata_valid=0`; a subsequent full read returns intact data.

Source files
------------

// File: rtl/l1_mem_responder.sv
// Line-burst backing memory below the L1 data cache: one read or write line
// request at a time, 32-bit beats, programmable read latency, registered rdata.
module l1_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 64,
  parameter int MEM_WORDS  = 1024,
  parameter int RD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wdata_valid,
  input  logic [31:0]           wdata,
  output logic                  wdata_ready,
  output logic                  wr_done,
  output logic                  rdata_valid,
  output logic [31:0]           rdata,
  output logic                  rdata_last,
  input  logic                  rdata_ready,
  output logic [2:0]            dbg_state
);

  localparam int BEATS  = LINE_BYTES / 4;
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0]  BEAT_MASK = IDX_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [3:0]        RD_LAT    = 4'(RD_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_RBURST = 3'd2,
    S_WBURST = 3'd3,
    S_WRESP  = 3'd4
  } state_t;

  // Handshakes: a transfer happens on the rising edge where both valid and
  // ready are high; once raised, rdata_valid/rdata/rdata_last hold until taken.

  logic [31:0] mem [MEM_WORDS];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  base_q, base_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [IDX_W-1:0]  req_base;
  logic              last_beat;

  // Line-aligned word index; upper address bits alias modulo the array depth.
  assign req_base  = req_addr[IDX_W+1:2] & ~BEAT_MASK;
  assign last_beat = (beat_q == LAST_BEAT);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[1:0]};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    mem_widx = base_q + IDX_W'(beat_q);
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          base_d = req_base;
          beat_d = '0;
          cnt_d  = '0;
          if (req_write) begin
            state_d = S_WBURST;
          end else if (RD_LATENCY == 0) begin
            state_d = S_RBURST;
            rdata_d = mem[req_base];
          end else begin
            state_d = S_WAIT;
            cnt_d   = RD_LAT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RBURST;
          cnt_d   = '0;
          rdata_d = mem[base_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RBURST: begin
        if (rdata_ready) begin
          if (last_beat) begin
            state_d = S_IDLE;
            beat_d  = '0;
            rdata_d = '0;
          end else begin
            // Prefetch the following word so the next beat has no bubble.
            beat_d  = beat_q + BEAT_W'(1);
            rdata_d = mem[base_q + IDX_W'(beat_q) + IDX_W'(1)];
          end
        end
      end
      S_WBURST: begin
        if (wdata_valid) begin
          mem_we = !rst;
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            state_d = S_WRESP;
            beat_d  = '0;
          end
        end
      end
      S_WRESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents survive reset; only the protocol can modify them.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= wdata;
  end

  assign req_ready   = (state_q == S_IDLE);
  assign wdata_ready = (state_q == S_WBURST);
  assign wr_done     = (state_q == S_WRESP);
  assign rdata_valid = (state_q == S_RBURST);
  assign rdata_last  = (state_q == S_RBURST) && last_beat;
  assign rdata       = rdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_l1_mem_responder.sv
// Bench for l1_mem_responder: directed scenarios plus randomized line traffic,
// checked by a decoupled monitor against a word-array reference model.
module tb_l1_mem_responder;

  localparam int ADDR_WIDTH = 32;
  localparam int LINE_BYTES = 64;
  localparam int MEM_WORDS  = 1024;
  localparam int RD_LATENCY = 4;
  localparam int BEATS      = LINE_BYTES / 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_write = 1'b0;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic                  wdata_valid = 1'b0;
  logic [31:0]           wdata = '0;
  logic                  wdata_ready;
  logic                  wr_done;
  logic                  rdata_valid;
  logic [31:0]           rdata;
  logic                  rdata_last;
  logic                  rdata_ready = 1'b1;
  logic [2:0]            dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  l1_mem_responder #(
    .ADDR_WIDTH(ADDR_WIDTH), .LINE_BYTES(LINE_BYTES),
    .MEM_WORDS(MEM_WORDS), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .wr_done(wr_done),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .rdata_ready(rdata_ready),
    .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: plain word array indexed by aliased word address.
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] wbuf [BEATS];
  logic [32:0] exp_q[$];   // {last, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no event expected event within budget", name);
  endtask

  function automatic int line_base(input logic [31:0] addr);
    return int'(((addr >> 2) & ~32'(BEATS - 1)) % MEM_WORDS);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int   lat_cnt = 0;
  bit   lat_armed = 0;
  int   wbeat = 0;
  bit   wr_pend = 0;
  bit   hold_pend = 0;
  logic [31:0] hold_data;
  logic hold_last;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      lat_armed = 0;
      wbeat     = 0;
      wr_pend   = 0;
      hold_pend = 0;
    end else begin
      check("wr_done", 64'(wr_done), 64'(wr_pend));
      wr_pend = 0;
      if (wdata_valid && wdata_ready) begin
        wbeat++;
        if (wbeat == BEATS) begin
          wbeat   = 0;
          wr_pend = 1;
        end
      end
      if (lat_armed) begin
        lat_cnt++;
        if (rdata_valid) begin
          check("first_beat_latency", 64'(lat_cnt), 64'(RD_LATENCY + 1));
          lat_armed = 0;
        end else if (lat_cnt > RD_LATENCY + 8) begin
          fail_note("first_beat_timeout");
          lat_armed = 0;
        end
      end
      if (req_valid && req_ready && !req_write) begin
        lat_armed = 1;
        lat_cnt   = 0;
      end
      if (hold_pend) begin
        check("hold_valid", 64'(rdata_valid), 64'(1));
        check("hold_data_last", {31'b0, rdata_last, rdata}, {31'b0, hold_last, hold_data});
        hold_pend = 0;
      end
      if (rdata_valid && !rdata_ready) begin
        hold_pend = 1;
        hold_data = rdata;
        hold_last = rdata_last;
      end
      if (rdata_valid && rdata_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected no beat", rdata);
        end else begin
          check("rbeat", {31'b0, rdata_last, rdata}, 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_req(input logic wr, input logic [31:0] addr);
    int guard = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 100);
    if (!req_ready) fail_note("accept_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic write_line(input logic [31:0] addr, input int gaps);
    int base;
    int guard;
    base = line_base(addr);
    for (int i = 0; i < BEATS; i++) ref_mem[base + i] = wbuf[i];
    issue_req(1'b1, addr);
    for (int i = 0; i < BEATS; i++) begin
      if (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1)) begin
        wdata_valid = 1'b0;
        wdata       = $urandom;
        @(posedge clk); #1;
      end
      wdata_valid = 1'b1;
      wdata       = wbuf[i];
      guard       = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!wdata_ready && guard < 50);
      if (!wdata_ready) fail_note("wdata_ready_timeout");
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
  endtask

  task automatic read_line(input logic [31:0] addr, input bit rand_bp, input int stall_at,
                           input int stall_len, input int rst_at, input int poke_at);
    int base;
    int hs = 0;
    int stall_left = 0;
    bit stalled = 0;
    int guard = 0;
    base = line_base(addr);
    for (int i = 0; i < BEATS; i++) exp_q.push_back({(i == BEATS - 1), ref_mem[base + i]});
    rdata_ready = 1'b1;
    issue_req(1'b0, addr);
    while (hs < BEATS) begin
      @(negedge clk);
      if (rdata_valid && rdata_ready) hs++;
      if (req_valid) check("busy_req_ready", 64'(req_ready), 64'(0));
      guard++;
      if (guard > 400) begin
        fail_note("read_timeout");
        break;
      end
      @(posedge clk); #1;
      req_valid   = 1'b0;
      // Junk write beats outside WBURST must be ignored.
      wdata_valid = 1'($urandom_range(0, 1));
      wdata       = $urandom;
      if (rst_at >= 0 && hs == rst_at) begin
        wdata_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_rdata_valid", 64'(rdata_valid), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(1));
        check("midrst_rdata", 64'(rdata), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        rdata_ready = 1'b1;
        return;
      end
      if (poke_at >= 0 && hs == poke_at) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = $urandom;
      end
      if (stall_at >= 0 && !stalled && hs == stall_at && rdata_valid) begin
        stalled    = 1;
        stall_left = stall_len;
      end
      if (stall_left > 0) begin
        rdata_ready = 1'b0;
        stall_left--;
      end else if (rand_bp) begin
        rdata_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rdata_ready = 1'b1;
      end
    end
    req_valid   = 1'b0;
    wdata_valid = 1'b0;
    rdata_ready = 1'b1;
    check("read_handshakes", 64'(hs), 64'(BEATS));
    check("read_drained", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] addr;
    int line;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_rdata_valid", 64'(rdata_valid), 64'(0));
    check("rst_wdata_ready", 64'(wdata_ready), 64'(0));
    check("rst_wr_done", 64'(wr_done), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < BEATS; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
    write_line(32'h0000_0040, 0);
    read_line(32'h0000_0044, 1'b0, -1, 0, -1, -1);

    read_line(32'h0000_0040, 1'b0, 7, 3, -1, -1);

    for (int i = 0; i < BEATS; i++) wbuf[i] = $urandom;
    write_line(32'h0000_0080, 1);
    read_line(32'h0000_0080, 1'b0, -1, 0, -1, -1);

    for (int i = 0; i < BEATS; i++) wbuf[i] = 32'h5A5A_0000 + 32'(i * 257);
    write_line(32'h0000_0000, 0);
    read_line(32'(MEM_WORDS * 4), 1'b0, -1, 0, -1, 8);

    read_line(32'h0000_0040, 1'b0, -1, 0, 3, -1);
    read_line(32'h0000_0040, 1'b0, -1, 0, -1, -1);

    for (int l = 3; l < 8; l++) begin
      for (int i = 0; i < BEATS; i++) wbuf[i] = $urandom;
      write_line(32'(l * LINE_BYTES), 2);
    end
    for (int n = 0; n < 24; n++) begin
      line = $urandom_range(0, 7);
      addr = 32'(line * LINE_BYTES) + 32'($urandom_range(0, LINE_BYTES - 1))
           + 32'($urandom_range(0, 3) * MEM_WORDS * 4);
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < BEATS; i++) wbuf[i] = $urandom;
        write_line(addr, 2);
      end else begin
        read_line(addr, 1'b1, -1, 0, -1, $urandom_range(0, 1) == 1 ? 5 : -1);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("final_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
